// File: rtl/dmem_bridge.sv
// Data-memory bridge: routes core load/store requests to a synchronous-read TCM,
// a small sim-control MMIO block, or flags them as unmapped.
module dmem_bridge #(
  parameter logic [31:0] TCM_BASE    = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h9000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic [13:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_wr_o,
  input  logic [31:0] ram_data_i,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        console_valid_o,
  output logic [7:0]  console_char_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cycle_q;
  logic [31:0]      rd_data_q;
  logic             tcm_rd_pend_q;
  logic [31:0]      tohost_q;
  logic             tohost_valid_q;
  logic [7:0]       console_q;
  logic             console_valid_q;
  logic             bus_err_q;

  logic        is_wr_c, req_c, tcm_hit_c, mmio_hit_c, accept_c, acc_c;
  logic [31:0] rd_val_c;
  logic        unused_c;

  assign is_wr_c    = (mem_d_wr_i != 4'h0);
  assign req_c      = mem_d_rd_i | is_wr_c;
  assign tcm_hit_c  = (mem_d_addr_i[31:16] == TCM_BASE[31:16]);
  assign mmio_hit_c = (mem_d_addr_i[31:4] == MMIO_BASE[31:4]);
  assign accept_c   = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !rst_i;
  assign acc_c      = accept_c & req_c;
  assign unused_c   = ^mem_d_addr_i[1:0];

  assign mem_d_accept_o  = accept_c;
  assign mem_d_ack_o     = (state_q == ST_RESP);
  // RAM data arrives one cycle after the read is accepted; bypass it straight out
  // in that cycle so zero-wait reads can be acked without an extra stage.
  assign mem_d_data_rd_o = tcm_rd_pend_q ? ram_data_i : rd_data_q;
  assign ram_addr_o      = mem_d_addr_i[15:2];
  assign ram_data_o      = mem_d_data_wr_i;
  assign ram_wr_o        = (acc_c && tcm_hit_c) ? mem_d_wr_i : 4'h0;
  assign tohost_valid_o  = tohost_valid_q;
  assign tohost_data_o   = tohost_q;
  assign console_valid_o = console_valid_q;
  assign console_char_o  = console_q;
  assign bus_err_o       = bus_err_q;

  // Response sequencing: optional wait states between accept and ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (acc_c) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read value captured at accept for MMIO; TCM reads are filled in a cycle later.
  always_comb begin
    rd_val_c = 32'h0;
    if (mmio_hit_c && !is_wr_c) begin
      case (mem_d_addr_i[3:2])
        2'd0:    rd_val_c = tohost_q;
        2'd2:    rd_val_c = cycle_q;
        default: rd_val_c = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      cycle_q         <= 32'h0;
      rd_data_q       <= 32'h0;
      tcm_rd_pend_q   <= 1'b0;
      tohost_q        <= 32'h0;
      tohost_valid_q  <= 1'b0;
      console_q       <= 8'h0;
      console_valid_q <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cycle_q         <= cycle_q + 32'd1;
      tohost_valid_q  <= 1'b0;
      console_valid_q <= 1'b0;
      tcm_rd_pend_q   <= acc_c && tcm_hit_c && !is_wr_c;
      if (tcm_rd_pend_q) begin
        rd_data_q <= ram_data_i;
      end
      // A new acceptance overrides the previous read's latched data.
      if (acc_c) begin
        rd_data_q <= rd_val_c;
        if (mem_d_rd_i && is_wr_c) begin
          bus_err_q <= 1'b1;
        end
        if (!tcm_hit_c && !mmio_hit_c) begin
          bus_err_q <= 1'b1;
        end
        if (mmio_hit_c && is_wr_c) begin
          case (mem_d_addr_i[3:2])
            2'd0: begin
              tohost_q       <= mem_d_data_wr_i;
              tohost_valid_q <= 1'b1;
            end
            2'd1: begin
              if (mem_d_wr_i[0]) begin
                console_q       <= mem_d_data_wr_i[7:0];
                console_valid_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
